// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : mips_pkg                                                      |
// | Description: Shared MIPS constants (opcodes, funct codes, register         |
// |              indices) and small decode helpers.                            |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package mips_pkg;

  // Datapath geometry
  localparam int C_DATA_W = 32;
  localparam int C_REG_N  = 32;
  localparam int C_RA_W   = 5;

  // Primary opcodes, Ins[31:26]
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LWL    = 6'h22;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes, Ins[5:0]
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;

  // Register indices and the canonical bubble
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_RA   = 5'd31;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  // R-type functs that do not produce a GPR result (HI/LO writers and JR).
  function automatic logic rtype_no_gpr_write(input logic [5:0] funct);
    return (funct == FN_JR)   || (funct == FN_MULT) || (funct == FN_MULTU) ||
           (funct == FN_DIV)  || (funct == FN_DIVU) || (funct == FN_MTHI)  ||
           (funct == FN_MTLO);
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : reg_file                                                      |
// | Description: 32x32 GPR file, two combinational read ports with write-      |
// |              through bypass, one write port, synchronous active-low clear. |
// | Ports      : CLK, RST (active-low sync), raddr1/raddr2 -> rdata1/rdata2,   |
// |              wen/waddr/wdata write port.                                   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int RA_W   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [RA_W-1:0]   raddr1,
  input  logic [RA_W-1:0]   raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              wen,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] r_gpr [REG_N];
  logic              w_wr_ok;

  // $0 is hardwired; a write aimed at it is simply discarded.
  assign w_wr_ok = wen && (waddr != RA_W'(REG_ZERO));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < REG_N; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_gpr[waddr] <= wdata;
    end
  end

  // Write-through: a same-cycle write is visible to the reader so the
  // decode stage never sees a stale operand from the WB stage.
  always_comb begin
    rdata1 = r_gpr[raddr1];
    rdata2 = r_gpr[raddr2];
    if (raddr1 == RA_W'(REG_ZERO)) begin
      rdata1 = '0;
    end else if (w_wr_ok && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
    if (raddr2 == RA_W'(REG_ZERO)) begin
      rdata2 = '0;
    end else if (w_wr_ok && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

endmodule : reg_file
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : id_stage                                                      |
// | Description: MIPS decode stage. Reads rs/rt from the GPR file, builds the  |
// |              extended immediate and destination index, and holds the       |
// |              ID/EX pipeline register feeding EX.                           |
// | Ports      : CLK, RST (active-low sync); Ins/nextPC from IF; Stall/Flush   |
// |              from hazard unit; Wen/Waddr/Wdata from WB; registered         |
// |              Ins_ex, nextPC_ex, Rdata1, Rdata2, Ed32, Wreg_ex, Valid_ex.   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int RA_W   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] Ins,
  input  logic [DATA_W-1:0] nextPC,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Wen,
  input  logic [RA_W-1:0]   Waddr,
  input  logic [DATA_W-1:0] Wdata,
  output logic [DATA_W-1:0] Ins_ex,
  output logic [DATA_W-1:0] nextPC_ex,
  output logic [DATA_W-1:0] Rdata1,
  output logic [DATA_W-1:0] Rdata2,
  output logic [DATA_W-1:0] Ed32,
  output logic [RA_W-1:0]   Wreg_ex,
  output logic              Valid_ex
);

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;

  assign w_op    = Ins[31:26];
  assign w_rs    = Ins[25:21];
  assign w_rt    = Ins[20:16];
  assign w_rd    = Ins[15:11];
  assign w_shamt = Ins[10:6];
  assign w_funct = Ins[5:0];
  assign w_imm   = Ins[15:0];

  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [DATA_W-1:0] w_ed32;
  logic [RA_W-1:0]   w_wreg;

  reg_file #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .RA_W   (RA_W)
  ) u_reg_file (
    .CLK    (CLK),
    .RST    (RST),
    .raddr1 (RA_W'(w_rs)),
    .raddr2 (RA_W'(w_rt)),
    .rdata1 (w_rdata1),
    .rdata2 (w_rdata2),
    .wen    (Wen),
    .waddr  (Waddr),
    .wdata  (Wdata)
  );

  // Immediate extension. Branch offsets stay unshifted; EX scales them.
  always_comb begin
    w_ed32 = {{(DATA_W-16){w_imm[15]}}, w_imm};
    case (w_op)
      OP_ANDI, OP_ORI, OP_XORI: w_ed32 = {{(DATA_W-16){1'b0}}, w_imm};
      OP_LUI:                   w_ed32 = {w_imm, {(DATA_W-16){1'b0}}};
      OP_RTYPE:                 w_ed32 = {{(DATA_W-5){1'b0}}, w_shamt};
      OP_J, OP_JAL:             w_ed32 = {{(DATA_W-26){1'b0}}, Ins[25:0]};
      default:                  w_ed32 = {{(DATA_W-16){w_imm[15]}}, w_imm};
    endcase
  end

  // Destination GPR; 0 means the instruction writes no GPR.
  always_comb begin
    w_wreg = RA_W'(REG_ZERO);
    case (w_op)
      OP_RTYPE: begin
        if (!rtype_no_gpr_write(w_funct)) begin
          w_wreg = RA_W'(w_rd);
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU: w_wreg = RA_W'(w_rt);
      OP_JAL:                                      w_wreg = RA_W'(REG_RA);
      default:                                     w_wreg = RA_W'(REG_ZERO);
    endcase
  end

  // While stalled, the held operands still track WB writes to their source
  // registers so the instruction does not leave ID with stale data.
  logic w_hold_upd1;
  logic w_hold_upd2;

  assign w_hold_upd1 = Wen && (Waddr != RA_W'(REG_ZERO)) &&
                       (Waddr == RA_W'(Ins_ex[25:21]));
  assign w_hold_upd2 = Wen && (Waddr != RA_W'(REG_ZERO)) &&
                       (Waddr == RA_W'(Ins_ex[20:16]));

  always_ff @(posedge CLK) begin
    if (!RST || Flush) begin
      Ins_ex    <= NOP;
      nextPC_ex <= '0;
      Rdata1    <= '0;
      Rdata2    <= '0;
      Ed32      <= '0;
      Wreg_ex   <= '0;
      Valid_ex  <= 1'b0;
    end else if (Stall) begin
      if (w_hold_upd1) begin
        Rdata1 <= Wdata;
      end
      if (w_hold_upd2) begin
        Rdata2 <= Wdata;
      end
    end else begin
      Ins_ex    <= Ins;
      nextPC_ex <= nextPC;
      Rdata1    <= w_rdata1;
      Rdata2    <= w_rdata2;
      Ed32      <= w_ed32;
      Wreg_ex   <= w_wreg;
      Valid_ex  <= 1'b1;
    end
  end

endmodule : id_stage
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_id_stage                                                   |
// | Description: Directed self-checking bench for id_stage.                    |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_id_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Ins;
  logic [31:0] nextPC;
  logic        Stall;
  logic        Flush;
  logic        Wen;
  logic [4:0]  Waddr;
  logic [31:0] Wdata;
  logic [31:0] Ins_ex;
  logic [31:0] nextPC_ex;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] Ed32;
  logic [4:0]  Wreg_ex;
  logic        Valid_ex;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  id_stage dut (
    .CLK       (CLK),
    .RST       (RST),
    .Ins       (Ins),
    .nextPC    (nextPC),
    .Stall     (Stall),
    .Flush     (Flush),
    .Wen       (Wen),
    .Waddr     (Waddr),
    .Wdata     (Wdata),
    .Ins_ex    (Ins_ex),
    .nextPC_ex (nextPC_ex),
    .Rdata1    (Rdata1),
    .Rdata2    (Rdata2),
    .Ed32      (Ed32),
    .Wreg_ex   (Wreg_ex),
    .Valid_ex  (Valid_ex)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle; inputs are changed after this returns.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rt_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Independent watchdog so the run can never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] add_a;
    RST = 1'b0; Ins = 32'h0; nextPC = 32'h0; Stall = 1'b0; Flush = 1'b0;
    Wen = 1'b0; Waddr = 5'd0; Wdata = 32'h0;

    // 1. Reset for two cycles, with garbage on the inputs
    Ins = 32'hFFFF_FFFF; nextPC = 32'h1234_5678;
    step(); step();
    check("rst_ins",    Ins_ex,            32'h0);
    check("rst_npc",    nextPC_ex,         32'h0);
    check("rst_rd1",    Rdata1,            32'h0);
    check("rst_rd2",    Rdata2,            32'h0);
    check("rst_ed",     Ed32,              32'h0);
    check("rst_wreg",   {27'h0, Wreg_ex},  32'h0);
    check("rst_valid",  {31'h0, Valid_ex}, 32'h0);
    RST = 1'b1;
    for (int i = 1; i < 32; i++) begin
      Ins = rt_ins(5'(i), 5'(32 - i), 5'd0, 5'd0, 6'h20);
      step();
      check($sformatf("rst_gpr%0d", i), Rdata1 | Rdata2, 32'h0);
    end

    // 2. Write with bypass, then stored read, then $0 write dropped
    Wen = 1'b1; Waddr = 5'd5; Wdata = 32'h0000_1234;
    Ins = rt_ins(5'd5, 5'd5, 5'd9, 5'd0, 6'h20); nextPC = 32'h0000_0104;
    step();
    check("byp_rd1",   Rdata1,            32'h0000_1234);
    check("byp_rd2",   Rdata2,            32'h0000_1234);
    check("add_wreg",  {27'h0, Wreg_ex},  32'd9);
    check("add_valid", {31'h0, Valid_ex}, 32'd1);
    check("add_ins",   Ins_ex,            32'h00A5_4820);
    check("add_npc",   nextPC_ex,         32'h0000_0104);
    Wen = 1'b0; nextPC = 32'h0000_0108;
    step();
    check("stored_rd1", Rdata1, 32'h0000_1234);
    Wen = 1'b1; Waddr = 5'd0; Wdata = 32'd7;
    Ins = rt_ins(5'd0, 5'd0, 5'd1, 5'd0, 6'h20);
    step();
    check("r0_byp", Rdata1, 32'h0);
    Wen = 1'b0;
    step();
    check("r0_read", Rdata2, 32'h0);

    // 3./4. Extension and destination decode
    Ins = i_ins(6'h08, 5'd0, 5'd3, 16'hFFF0); step();
    check("addi_ed", Ed32, 32'hFFFF_FFF0);  check("addi_wreg", {27'h0, Wreg_ex}, 32'd3);
    Ins = i_ins(6'h0D, 5'd0, 5'd3, 16'hFFF0); step();
    check("ori_ed", Ed32, 32'h0000_FFF0);
    Ins = i_ins(6'h0F, 5'd0, 5'd2, 16'h00AB); step();
    check("lui_ed", Ed32, 32'h00AB_0000);   check("lui_wreg", {27'h0, Wreg_ex}, 32'd2);
    Ins = rt_ins(5'd0, 5'd5, 5'd6, 5'd3, 6'h03); step();
    check("sra_ed", Ed32, 32'd3);           check("sra_wreg", {27'h0, Wreg_ex}, 32'd6);
    Ins = {6'h02, 26'h3FF_FFFF}; step();
    check("j_ed", Ed32, 32'h03FF_FFFF);     check("j_wreg", {27'h0, Wreg_ex}, 32'd0);
    Ins = i_ins(6'h04, 5'd1, 5'd2, 16'h8000); step();
    check("beq_ed", Ed32, 32'hFFFF_8000);   check("beq_wreg", {27'h0, Wreg_ex}, 32'd0);
    Ins = i_ins(6'h09, 5'd0, 5'd4, 16'h0001); step();
    check("addiu_wreg", {27'h0, Wreg_ex}, 32'd4);
    Ins = {6'h03, 26'h000_0040}; step();
    check("jal_wreg", {27'h0, Wreg_ex}, 32'd31);
    Ins = i_ins(6'h2B, 5'd1, 5'd7, 16'h0010); step();
    check("sw_wreg", {27'h0, Wreg_ex}, 32'd0);
    Ins = rt_ins(5'd1, 5'd2, 5'd7, 5'd0, 6'h18); step();
    check("mult_wreg", {27'h0, Wreg_ex}, 32'd0);
    Ins = rt_ins(5'd5, 5'd0, 5'd12, 5'd0, 6'h09); step();
    check("jalr_wreg", {27'h0, Wreg_ex}, 32'd12);
    Ins = rt_ins(5'd5, 5'd0, 5'd12, 5'd0, 6'h08); step();
    check("jr_wreg", {27'h0, Wreg_ex}, 32'd0);
    Ins = i_ins(6'h23, 5'd5, 5'd8, 16'hFFFC); step();
    check("lw_wreg", {27'h0, Wreg_ex}, 32'd8); check("lw_ed", Ed32, 32'hFFFF_FFFC);
    check("lw_rd1", Rdata1, 32'h0000_1234);

    // 5. Stall with operand refresh, then Flush over Stall
    add_a = rt_ins(5'd5, 5'd6, 5'd9, 5'd0, 6'h20);
    Ins = add_a; nextPC = 32'h0000_0200; step();
    check("pre_stall_rd2", Rdata2, 32'h0);
    Stall = 1'b1; Ins = i_ins(6'h0F, 5'd0, 5'd2, 16'h5555); nextPC = 32'h0000_0300;
    step();
    check("stall1_ins", Ins_ex, add_a);
    check("stall1_npc", nextPC_ex, 32'h0000_0200);
    Wen = 1'b1; Waddr = 5'd5; Wdata = 32'h0000_BEEF;
    step();
    check("stall2_rd1", Rdata1, 32'h0000_BEEF);
    check("stall2_rd2", Rdata2, 32'h0);
    Waddr = 5'd6; Wdata = 32'h0000_CAFE;
    step();
    check("stall3_rd2", Rdata2, 32'h0000_CAFE);
    check("stall3_rd1", Rdata1, 32'h0000_BEEF);
    check("stall3_ins", Ins_ex, add_a);
    Wen = 1'b0; Flush = 1'b1;
    step();
    check("flush_ins",   Ins_ex,            32'h0);
    check("flush_valid", {31'h0, Valid_ex}, 32'h0);
    check("flush_rd1",   Rdata1,            32'h0);
    Flush = 1'b0; Stall = 1'b0;

    // 6. Reset while stalled
    Ins = add_a; step();
    check("pre_rst_rd1",   Rdata1,            32'h0000_BEEF);
    check("pre_rst_valid", {31'h0, Valid_ex}, 32'd1);
    Stall = 1'b1; RST = 1'b0;
    step();
    check("midrst_ins",   Ins_ex,            32'h0);
    check("midrst_rd1",   Rdata1,            32'h0);
    check("midrst_valid", {31'h0, Valid_ex}, 32'h0);
    RST = 1'b1; Stall = 1'b0;
    step();
    check("post_rst_rd1",   Rdata1,            32'h0);
    check("post_rst_rd2",   Rdata2,            32'h0);
    check("post_rst_valid", {31'h0, Valid_ex}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_id_stage
`default_nettype wire
